// File: rtl/fifo_umbral_param.sv
// fifo_umbral_param: parametrised synchronous FIFO with programmable almost flags and sticky error flags
module fifo_umbral_param #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   alto,
    input  logic [ADDR_W:0]   bajo,
    input  logic              err_clear,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    always_comb begin
        full         = count == (ADDR_W+1)'(DEPTH);
        empty        = count == '0;
        almost_full  = count >= alto;
        almost_empty = count <= bajo;
        push_ok      = push & (~full | pop);
        pop_ok       = pop & ~empty;
    end
    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= data_in;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            valid_out <= pop_ok;
            count     <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
            overflow  <= (push & ~push_ok) | (overflow & ~err_clear);
            underflow <= (pop & ~pop_ok) | (underflow & ~err_clear);
        end
    end
endmodule

// File: doc/fifo_umbral_param.md
Name: fifo_umbral_param

Overview:
Parametrised synchronous FIFO, the successor to the current push/pop FIFO. Width and depth are generic. It has programmable almost-full/almost-empty thresholds (alto/bajo), an occupancy count, registered read data with a valid strobe, and sticky overflow/underflow error flags. It sits between producer and consumer stages of the data path. The almost flags drive upstream flow control.

Parameters:
- DATA_W, 10, width of each data word.
- ADDR_W, 3, address width; depth DEPTH = 2**ADDR_W (8 by default).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request; data_in is captured when the write is accepted.
- data_in  input  DATA_W  write data.
- pop  input  1  read request.
- alto  input  ADDR_W+1  almost-full threshold (occupancy).
- bajo  input  ADDR_W+1  almost-empty threshold (occupancy).
- err_clear  input  1  synchronous clear of the sticky error flags.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  data_out holds a newly popped word this cycle.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= alto.
- almost_empty  output  1  count <= bajo.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, on assertion, independent of clk):
  - wr_ptr, rd_ptr, count, data_out and valid_out go to 0.
  - overflow and underflow go to 0.
  - empty=1, full=0.
  - almost_full and almost_empty follow their formulas from count=0.
  - Memory contents are not reset.
- Storage: DEPTH x DATA_W array. wr_ptr and rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0. count is a separate ADDR_W+1-bit register.
- Accept rules, evaluated on the pre-edge state:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
  - Consequences:
    - A push on full with a simultaneous pop is accepted: the pop frees a slot in the same edge and count stays at DEPTH.
    - A pop on empty is never accepted. There is no bypass, even with a simultaneous push. The push is still accepted and count becomes 1.
- On the edge:
  - push_ok: mem[wr_ptr] <= data_in; wr_ptr+1.
  - pop_ok: data_out <= mem[rd_ptr]; rd_ptr+1.
  - count: +1 if push_ok only, -1 if pop_ok only, unchanged if both or neither.
- Read latency: one cycle. valid_out=1 for exactly the cycle after an accepted pop, else 0. data_out holds its last value when no pop is accepted.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational from the registered count and the alto/bajo inputs.
  - They are valid in the same cycle as count; they are not delayed.
  - alto/bajo may change at any time; the flags track immediately.
  - alto=0 makes almost_full constantly 1.
  - bajo>=DEPTH makes almost_empty constantly 1.
- Error flags:
  - overflow is set at the edge where push=1 and push_ok=0; the word is dropped and the pointer does not move.
  - underflow is set at the edge where pop=1 and pop_ok=0; valid_out stays 0.
  - Both are sticky until reset, or until an edge with err_clear=1.
  - Set has priority over err_clear in the same edge.
- Reset mid-operation:
  - Any in-flight pop result is discarded.
  - After reset deasserts, the FIFO behaves as empty.
  - Old memory contents are never visible on data_out.

Test Plan:
All scenarios use DATA_W=10, ADDR_W=3, alto=6, bajo=1.

1. Fill:
   - Stimulus: reset, then push 8 words 0x090..0x097, one per edge.
   - Required: count steps 1..8; almost_empty drops once count reaches 2; almost_full rises once count reaches 6; full=1 at count 8; overflow=0.
2. Overflow:
   - Stimulus: with the FIFO full, push 0x098 with no pop.
   - Required: overflow=1 and stays 1; count=8; pop 8 words; assert err_clear for one edge.
   - Required after that: 0x098 never appears on data_out; overflow returns to 0.
3. Drain and underflow:
   - Stimulus: pop 8 words, then pop once more on empty.
   - Required: data_out = 0x090..0x097, each with valid_out=1 one cycle after its pop; then empty=1; the extra pop sets underflow=1 with valid_out=0.
4. Simultaneous push/pop:
   - At count 4: count stays 4 and order is preserved.
   - At count 8 (full): both accepted, count stays 8, no overflow.
   - At count 0 (empty): count becomes 1 and underflow=1.
5. Wrap-around:
   - Stimulus: 20 words 0x100..0x113 with interleaved push/pop, occupancy kept between 1 and 7.
   - Required: output order exactly 0x100..0x113; no flag errors.
6. Async reset:
   - Stimulus: assert reset mid-cycle while count=5 and a pop is in flight.
   - Required: count, data_out, valid_out and errors go to 0 before the next edge; empty=1; after release the next pop sets underflow.
